// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin write-port arbiter and hazard scoreboard for the 8x8 register file
// Optional scoreboard enabled by defining RF_SCOREBOARD_EN.
module rf_write_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  input  logic       rsv_valid,
  input  logic [2:0] rsv_addr,
  input  logic [2:0] rd_addr1,
  input  logic [2:0] rd_addr2,
  output logic       hazard1,
  output logic       hazard2,
  output logic [7:0] busy_mask
);

  logic       ptr;
  logic       grant0;
  logic       grant1;
  logic       grant;
  logic [2:0] grant_addr;
  logic [7:0] grant_data;

  // ptr = 0 favours requester 0 when both are pending
  always_comb begin
    grant0     = !rst && req0_valid && (!req1_valid || !ptr);
    grant1     = !rst && req1_valid && (!req0_valid || ptr);
    grant      = grant0 || grant1;
    grant_addr = grant1 ? req1_addr : req0_addr;
    grant_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= 3'd0;
      rf_wdata <= 8'd0;
    end else begin
      if (grant) begin
        ptr      <= grant0;
        rf_waddr <= grant_addr;
        rf_wdata <= grant_data;
      end
      // R0 writes are accepted but never strobed into the file
      rf_we <= grant && (grant_addr != 3'd0);
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [7:0] busy;
  logic [7:0] busy_next;

  // reserve is applied after the clear so it wins on a same-edge collision
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (rsv_valid) busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 8'd0;
    else     busy <= busy_next;
  end

  assign busy_mask = busy;
  assign hazard1   = busy[rd_addr1];
  assign hazard2   = busy[rd_addr2];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{rsv_valid, rsv_addr, rd_addr1, rd_addr2};
  assign busy_mask = 8'd0;
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
`endif

endmodule
